// File: rtl/cic_pkg.sv
// Shared types and helpers for the multichannel CIC decimator: FSM state
// encoding, saturation, accumulator width check and DC-blocker constants.
package cic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COMB,
      SCALE,
      DC,
      EMIT
   } cic_state_e;

   localparam int DC_STEP  = 4;
   localparam int DC_SHIFT = 8;

   function automatic int cicMinWidth(input int stages, input int decim);
      return stages * $clog2(decim) + 1;
   endfunction

   // Clamp a wide signed value into the range of a w-bit signed word.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
      logic signed [63:0] hiLim;
      logic signed [63:0] loLim;
      hiLim = (64'sd1 <<< (w - 1)) - 64'sd1;
      loLim = -(64'sd1 <<< (w - 1));
      if (v > hiLim) begin
         return hiLim;
      end else if (v < loLim) begin
         return loLim;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/cic_integrator_n.sv
// N-stage CIC integrator cascade for one PDM channel; all stages advance
// together on each sample strobe and wrap modulo 2^WIDTH.
module cic_integrator_n #(
   parameter int STAGES = 4,
   parameter int WIDTH  = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stb_sample,
   input  logic             din,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] acc_q [STAGES];

   // Every stage adds the previous stage's old value, so the cascade is one
   // sample deep per stage rather than combinationally chained.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            acc_q[k] <= '0;
         end
      end else if (stb_sample) begin
         acc_q[0] <= acc_q[0] + (din ? WIDTH'(1) : '1);
         for (int k = 1; k < STAGES; k++) begin
            acc_q[k] <= acc_q[k] + acc_q[k-1];
         end
      end
   end

   assign out = acc_q[STAGES-1];

endmodule

// File: rtl/cic_decimator.sv
// Multichannel PDM-to-PCM CIC decimator with a shared, time-multiplexed
// comb/scale datapath. Optional DC blocker enabled by CIC_DC_BLOCK_EN.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int STAGES   = 4,
   parameter int DECIM    = 125,
   parameter int WIDTH    = 30,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 13,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CHANNELS-1:0]     stb_sample,
   input  logic [CHANNELS-1:0]     din,
   input  logic                    stb_pcm,
   output logic                    busy,
   output logic                    overrun,
   output logic                    out_valid,
   output logic [CW-1:0]           out_chan,
   output logic signed [OUT_W-1:0] out_data
);

   localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

   if (WIDTH < cicMinWidth(STAGES, DECIM)) begin : gWidthCheck
      $error("cic_decimator: WIDTH is too small for STAGES and DECIM");
   end

   logic [WIDTH-1:0]        integOut [CHANNELS];
   logic [WIDTH-1:0]        snap_q   [CHANNELS];
   logic [WIDTH-1:0]        dly_q    [CHANNELS][STAGES];
   logic [WIDTH-1:0]        x_q;
   logic signed [OUT_W-1:0] s_q;
   cic_state_e              state_q;
   logic [CW-1:0]           ch_q;
   logic [SW-1:0]           stage_q;
   logic                    busy_q;
   logic                    overrun_q;
   logic                    outValid_q;
   logic [CW-1:0]           outChan_q;
   logic signed [OUT_W-1:0] outData_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : gInteg
      cic_integrator_n #(
         .STAGES(STAGES),
         .WIDTH (WIDTH)
      ) uInteg (
         .clk       (clk),
         .rst       (rst),
         .stb_sample(stb_sample[c]),
         .din       (din[c]),
         .out       (integOut[c])
      );
   end

   logic [WIDTH-1:0]        combIn;
   logic [WIDTH-1:0]        combOut_d;
   logic signed [63:0]      xExt;
   logic signed [OUT_W-1:0] scaled_d;

   // The first comb stage of each channel starts from that channel's snapshot.
   always_comb begin
      combIn    = (stage_q == '0) ? snap_q[ch_q] : x_q;
      combOut_d = combIn - dly_q[ch_q][stage_q];
      xExt      = {{(64-WIDTH){x_q[WIDTH-1]}}, x_q};
      scaled_d  = OUT_W'(sat(xExt >>> SHIFT, OUT_W));
   end

`ifdef CIC_DC_BLOCK_EN
   logic [WIDTH-1:0]        bias_q [CHANNELS];
   logic signed [63:0]      sExt;
   logic signed [63:0]      biasExt;
   logic signed [OUT_W-1:0] dcOut_d;

   always_comb begin
      sExt    = 64'(s_q);
      biasExt = {{(64-WIDTH){bias_q[ch_q][WIDTH-1]}}, bias_q[ch_q]};
      dcOut_d = OUT_W'(sat(sExt + (biasExt >>> DC_SHIFT), OUT_W));
   end
`endif

   // Pass sequencer: snapshot on an accepted strobe, then comb, scale and
   // emit each channel in turn. Overlapping strobes are only flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         stage_q    <= '0;
         x_q        <= '0;
         s_q        <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         outValid_q <= 1'b0;
         outChan_q  <= '0;
         outData_q  <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            snap_q[c] <= '0;
`ifdef CIC_DC_BLOCK_EN
            bias_q[c] <= '0;
`endif
            for (int s = 0; s < STAGES; s++) begin
               dly_q[c][s] <= '0;
            end
         end
      end else begin
         outValid_q <= 1'b0;
         if (stb_pcm && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (stb_pcm) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     snap_q[c] <= integOut[c];
                  end
                  ch_q    <= '0;
                  stage_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= COMB;
               end
            end
            COMB: begin
               x_q                  <= combOut_d;
               dly_q[ch_q][stage_q] <= combIn;
               if (stage_q == SW'(STAGES - 1)) begin
                  state_q <= SCALE;
               end else begin
                  stage_q <= stage_q + 1'b1;
               end
            end
            SCALE: begin
               s_q <= scaled_d;
`ifdef CIC_DC_BLOCK_EN
               state_q <= DC;
`else
               state_q <= EMIT;
`endif
            end
            DC: begin
`ifdef CIC_DC_BLOCK_EN
               s_q          <= dcOut_d;
               bias_q[ch_q] <= bias_q[ch_q] + ((dcOut_d < 0) ? WIDTH'(DC_STEP) : -WIDTH'(DC_STEP));
`endif
               state_q <= EMIT;
            end
            EMIT: begin
               outData_q  <= s_q;
               outChan_q  <= ch_q;
               outValid_q <= 1'b1;
               stage_q    <= '0;
               if (ch_q == CW'(CHANNELS - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  ch_q    <= ch_q + 1'b1;
                  state_q <= COMB;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign out_valid = outValid_q;
   assign out_chan  = outChan_q;
   assign out_data  = outData_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator (default build): expected PCM words,
// channels and pulse cycles are queued at stb_pcm and checked on out_valid.
module tb_cic_decimator;

   localparam int CH = 2;
   localparam int P  = 6;

   logic              clk       = 1'b0;
   logic              rst       = 1'b1;
   logic [1:0]        stbSample = 2'b00;
   logic [1:0]        din       = 2'b00;
   logic              stbPcm    = 1'b0;
   logic              busy;
   logic              overrun;
   logic              outValid;
   logic [0:0]        outChan;
   logic signed [15:0] outData;
   logic              satBusy;
   logic              satOverrun;
   logic              satValid;
   logic [0:0]        satChan;
   logic signed [15:0] satData;

   typedef struct {
      int chan;
      int lo;
      int hi;
      bit chkData;
      int cyc;
   } exp_t;

   exp_t sbQueue[$];
   exp_t popped;
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   cic_decimator dut (
      .clk       (clk),
      .rst       (rst),
      .stb_sample(stbSample),
      .din       (din),
      .stb_pcm   (stbPcm),
      .busy      (busy),
      .overrun   (overrun),
      .out_valid (outValid),
      .out_chan  (outChan),
      .out_data  (outData)
   );

   // Smaller shift drives the scaled result past the 16-bit limits.
   cic_decimator #(.SHIFT(12)) dutSat (
      .clk       (clk),
      .rst       (rst),
      .stb_sample(stbSample),
      .din       (din),
      .stb_pcm   (stbPcm),
      .busy      (satBusy),
      .overrun   (satOverrun),
      .out_valid (satValid),
      .out_chan  (satChan),
      .out_data  (satData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int act, input int lo, input int hi);
      compared++;
      if (act < lo || act > hi) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Hand-derived outputs for a constant input: snapshot k holds C(125k,4).
   function automatic int expConst(input int k, input bit neg);
      int v;
      case (k)
         1:       v = 1183;
         2:       v = 14662;
         3:       v = 28500;
         default: v = 29802;
      endcase
      return neg ? (-v - 1) : v;
   endfunction

   // Monitor: every out_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (outValid === 1'b1) begin
         if (sbQueue.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_pulse: got chan %0d data %0d at cycle %0d, required no pulse",
                     outChan, outData, cyc);
         end else begin
            popped = sbQueue.pop_front();
            checkOutput("out_chan", int'(outChan), popped.chan, popped.chan);
            checkOutput("pulse_cycle", cyc, popped.cyc, popped.cyc);
            checkOutput("busy_at_pulse", int'(busy), (popped.chan == CH-1) ? 0 : 1,
                        (popped.chan == CH-1) ? 0 : 1);
            if (popped.chkData) begin
               checkOutput("out_data", int'(outData), popped.lo, popped.hi);
            end
         end
      end
   end

   task automatic pushPass(input int k, input int mode);
      for (int c = 0; c < CH; c++) begin
         exp_t e;
         e.chan    = c;
         e.cyc     = cyc + (c + 1) * P + 1;
         e.chkData = 1'b1;
         if (mode == 1) begin
            e.lo = expConst(k, 1'b1);
         end else if (mode == 2 && c == 0) begin
            e.lo      = -1;
            e.chkData = (k >= 5);
         end else begin
            e.lo = expConst(k, 1'b0);
         end
         e.hi = (mode == 2 && c == 0) ? 0 : e.lo;
         sbQueue.push_back(e);
      end
   endtask

   // mode 0: din all ones, 1: all zeros, 2: ch0 alternates per strobe, ch1 ones.
   task automatic applyStimulus(input int nPer, input int mode);
      int  k   = 0;
      logic alt = 1'b1;
      for (int cnt = 0; cnt < nPer * 2000 + 40; cnt++) begin
         @(negedge clk);
         stbSample = (cnt % 16 == 0) ? 2'b11 : 2'b00;
         if (cnt % 16 == 0) begin
            case (mode)
               0:       din = 2'b11;
               1:       din = 2'b00;
               default: begin
                  din = {1'b1, alt};
                  alt = ~alt;
               end
            endcase
         end
         stbPcm = (cnt > 0) && (cnt % 2000 == 0) && (cnt <= nPer * 2000);
         if (stbPcm) begin
            k++;
            pushPass(k, mode);
         end
      end
      @(negedge clk);
      stbSample = 2'b00;
      stbPcm    = 1'b0;
      checkOutput("pending_outputs", sbQueue.size(), 0, 0);
      sbQueue.delete();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pushZeroPass();
      for (int c = 0; c < CH; c++) begin
         sbQueue.push_back('{chan: c, lo: 0, hi: 0, chkData: 1'b1, cyc: cyc + (c + 1) * P + 1});
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0, 0);
      checkOutput("reset_overrun", int'(overrun), 0, 0);
      checkOutput("reset_out_valid", int'(outValid), 0, 0);
      checkOutput("reset_out_chan", int'(outChan), 0, 0);
      checkOutput("reset_out_data", int'(outData), 0, 0);
      rst = 1'b0;

      $display("[TB] constant +1 input");
      applyStimulus(6, 0);
      checkOutput("sat_positive", int'(satData), 32767, 32767);

      $display("[TB] constant -1 input");
      doReset();
      applyStimulus(6, 1);
      checkOutput("sat_negative", int'(satData), -32768, -32768);

      $display("[TB] alternating ch0, constant ch1");
      doReset();
      applyStimulus(6, 2);

      $display("[TB] overrun");
      doReset();
      @(negedge clk);
      stbPcm = 1'b1;
      pushZeroPass();
      @(negedge clk);
      stbPcm = 1'b0;
      checkOutput("busy_after_pcm", int'(busy), 1, 1);
      checkOutput("overrun_before", int'(overrun), 0, 0);
      @(negedge clk);
      @(negedge clk);
      stbPcm = 1'b1;
      @(negedge clk);
      stbPcm = 1'b0;
      checkOutput("overrun_set", int'(overrun), 1, 1);
      repeat (20) @(negedge clk);
      checkOutput("overrun_pulses", sbQueue.size(), 0, 0);
      checkOutput("overrun_sticky", int'(overrun), 1, 1);
      @(negedge clk);
      stbPcm = 1'b1;
      pushZeroPass();
      @(negedge clk);
      stbPcm = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("after_overrun_pulses", sbQueue.size(), 0, 0);
      checkOutput("overrun_still", int'(overrun), 1, 1);
      sbQueue.delete();

      $display("[TB] reset mid-pass and replay");
      doReset();
      @(negedge clk);
      checkOutput("overrun_cleared", int'(overrun), 0, 0);
      applyStimulus(2, 0);
      @(negedge clk);
      stbPcm = 1'b1;
      sbQueue.push_back('{chan: 0, lo: 0, hi: 0, chkData: 1'b0, cyc: cyc + P + 1});
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         stbPcm = 1'b0;
      end
      checkOutput("midpass_busy", int'(busy), 1, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", int'(busy), 0, 0);
      checkOutput("abort_out_valid", int'(outValid), 0, 0);
      checkOutput("abort_out_data", int'(outData), 0, 0);
      checkOutput("abort_out_chan", int'(outChan), 0, 0);
      checkOutput("abort_pending", sbQueue.size(), 0, 0);
      sbQueue.delete();
      rst = 1'b0;
      applyStimulus(6, 0);

      repeat (20) @(negedge clk);
      checkOutput("final_pending", sbQueue.size(), 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Parametrised multichannel PDM-to-PCM CIC decimator. It is the next generation of the fixed 4-stage, single-channel integrator/comb pair.
- Per-channel N-stage integrators run at the PDM strobe rate.
- One shared, time-multiplexed comb/scale/DC-block datapath runs once per PCM strobe.
- Produces one signed PCM word per channel per PCM period.
- Sits between the audio clock generator (strobes) and the PCM consumer (mixer/I2S).

Parameters:
- CHANNELS, 2: number of PDM inputs.
- STAGES, 4: integrator and comb stage count.
- DECIM, 125: PDM samples per PCM sample. Sets the required width only; timing comes from stb_pcm.
- WIDTH, 30: accumulator width. Must be >= STAGES*$clog2(DECIM)+1; elaboration $error otherwise.
- OUT_W, 16: PCM output width.
- SHIFT, 13: arithmetic right shift applied to the comb result before saturation.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- stb_sample, in, CHANNELS: per-channel PDM sample strobe.
- din, in, CHANNELS: PDM bit per channel; 1 = +1, 0 = -1.
- stb_pcm, in, 1: one-cycle strobe that starts a decimation pass.
- busy, out, 1: high from the cycle after an accepted stb_pcm until the final channel is emitted.
- overrun, out, 1: sticky; set when stb_pcm arrives while busy.
- out_valid, out, 1: one-cycle pulse per channel result.
- out_chan, out, $clog2(CHANNELS) (min 1): channel index of out_data.
- out_data, out, OUT_W: signed PCM sample.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All integrators, comb delays, snapshot registers and DC bias registers go to 0.
  - FSM goes to IDLE.
  - busy, overrun and out_valid go to 0; out_chan and out_data go to 0.
  - Reset mid-pass aborts the pass with no out_valid.
- Integrators:
  - On stb_sample[c], channel c updates: e0 += din[c] ? +1 : -1, and e[k] += e[k-1] for k = 1..STAGES-1.
  - All stages update in the same cycle, using old values.
  - Arithmetic is two's complement mod 2^WIDTH; wraparound is intended.
  - Integrators never pause, including while busy.
- Snapshot: in the stb_pcm cycle, if not busy, the last integrator of every channel is copied into snap[c].
  - If stb_sample and stb_pcm coincide, the snapshot takes the pre-update value.
- FSM, processing channels 0..CHANNELS-1 in order:
  - IDLE: on stb_pcm, go to COMB with ch=0, stage=0, and set busy.
  - COMB: one stage per cycle, for STAGES cycles.
    - x <= x - d[ch][stage]; d[ch][stage] <= x. The initial x is snap[ch].
    - Mod 2^WIDTH.
  - SCALE: s = sat_OUT_W(x >>> SHIFT). Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - DC: present only with DC_BLOCK_EN (see Optional Feature).
  - EMIT: register out_data and out_chan, and pulse out_valid the next cycle.
    - If ch = CHANNELS-1, go to IDLE and clear busy in the same cycle that out_valid is high.
    - Otherwise ch++ and go to COMB.
- Latency: out_valid for channel c is high exactly (c+1)*P+1 cycles after the stb_pcm cycle.
  - P = STAGES+2, or STAGES+3 with DC_BLOCK_EN.
- Overrun: stb_pcm while busy is ignored. There is no snapshot and the pass continues; overrun is set to 1 until rst.
- No backpressure: the consumer must accept out_valid on any cycle.
- Comb delay registers are updated only by completed passes.

Optional Feature:
- Macro: CIC_DC_BLOCK_EN.
- Defined:
  - Per-channel bias register b[c], WIDTH bits signed, reset 0.
  - A DC state follows SCALE: y = sat_OUT_W(s + (b[c] >>> 8)); b[c] <= b[c] + (y < 0 ? +4 : -4); out_data = y.
  - P = STAGES+3.
- Undefined: no bias registers and no DC state; out_data = s; P = STAGES+2.

Decomposition:
- Package cic_pkg holds:
  - the FSM state enum (IDLE, COMB, SCALE, DC, EMIT);
  - the sat() function;
  - the width-check constant function (STAGES*$clog2(DECIM)+1);
  - the DC step constant (4) and DC shift constant (8).
- Sub-module cic_integrator_n (params STAGES, WIDTH; ports clk, rst, stb_sample, din, out) is instantiated once per channel via generate.

Test Plan:
- Defaults; din = 2'b11; stb_sample every 16 clk; stb_pcm every 2000 clk; after 5 PCM periods -> out_data = 29802 on both channels; out_chan sequence 0,1.
- din = 2'b00, same timing -> out_data = -29803 steady. With CIC_DC_BLOCK_EN -> magnitude decreases monotonically toward 0.
- din alternating 1,0 on each strobe -> steady out_data in [-1,0]. Channel 1 held at 1 concurrently -> 29802, with no cross-talk.
- Latency check -> out_valid at exactly +7 and +13 cycles after stb_pcm (defaults, no DC block); busy low in the cycle of the second pulse.
- stb_pcm reasserted 3 cycles after a first stb_pcm -> overrun = 1 and stays 1; exactly CHANNELS pulses are emitted; the next pass is unaffected.
- rst asserted in the COMB state of channel 1 -> next cycle busy = 0, out_valid = 0, all state zero. With din held all-ones and the prior stimulus replayed, the output matches a fresh run bit-exactly.
